// File: rtl/namco_wsg_sequencer.sv
// ---------------------------------------------------------------------------
// namco_wsg_sequencer
//
// Time-multiplexed controller for a 3-voice waveform sound generator.
// Holds the CPU-written nibble sound registers. Once per sample tick it
// walks voices v0, v1, v2 in order. For each voice it:
//   - steps the voice's phase accumulator;
//   - fetches one sample through a single shared waveform ROM port;
//   - adds the volume-weighted sample into a running mix.
// The finished mix is presented on mix_out_o with a one-cycle mix_valid_o.
//
// Register map (voice v base = 8*v):
//   +0 wave[2:0] (bit 3 stored, unused)
//   +1..+5 freq nibbles, LS first
//          (v0: 20-bit, +1..+5; v1/v2: 16-bit, +1..+4, +5 ignored)
//   +6 volume
//   +7 and 0x18..0x1F ignored
//
// Ports:
//   clk_i          system clock
//   reset_i        asynchronous, active-high reset
//   sample_tick_i  one-cycle pulse at the audio sample rate
//   sound_enable_i 0 = accumulators hold, mix forced to 0
//   wr_en_i        sound-register write strobe
//   wr_addr_i      sound-register address (5 bits)
//   wr_data_i      sound-register nibble
//   rom_addr_o     shared waveform ROM address {wave, phase[top 5]}
//   rom_rd_o       high during the ADDR cycle of each voice
//   rom_data_i     waveform ROM byte; low nibble is the sample
//   mix_out_o      mixed sample, held between updates
//   mix_valid_o    one-cycle pulse when mix_out_o updates
//   busy_o         high whenever the sequencer is not idle
//   overrun_o      sticky; set when a tick arrives while busy
// ---------------------------------------------------------------------------
module namco_wsg_sequencer #(
    parameter int unsigned ROM_LATENCY = 1  // 1..4 cycles, rom_addr to rom_data
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       sample_tick_i,
    input  logic       sound_enable_i,
    input  logic       wr_en_i,
    input  logic [4:0] wr_addr_i,
    input  logic [3:0] wr_data_i,
    output logic [7:0] rom_addr_o,
    output logic       rom_rd_o,
    input  logic [7:0] rom_data_i,
    output logic [9:0] mix_out_o,
    output logic       mix_valid_o,
    output logic       busy_o,
    output logic       overrun_o
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWait,
        StAccum,
        StDone
    } state_e;

    // Terminal value of the WAIT counter: WAIT lasts exactly ROM_LATENCY cycles.
    localparam logic [1:0] LastWait = 2'(ROM_LATENCY - 1);

    // ------------------------------------------------------------------
    // Sound registers
    // ------------------------------------------------------------------
    logic [3:0]  wave_q [3];
    logic [3:0]  vol_q  [3];
    logic [19:0] freq0_q;
    logic [15:0] freq1_q;
    logic [15:0] freq2_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int v = 0; v < 3; v++) begin
                wave_q[v] <= '0;
                vol_q[v]  <= '0;
            end
            freq0_q <= '0;
            freq1_q <= '0;
            freq2_q <= '0;
        end else if (wr_en_i) begin
            case (wr_addr_i[4:3])
                2'd0: begin
                    case (wr_addr_i[2:0])
                        3'd0:    wave_q[0]       <= wr_data_i;
                        3'd1:    freq0_q[3:0]    <= wr_data_i;
                        3'd2:    freq0_q[7:4]    <= wr_data_i;
                        3'd3:    freq0_q[11:8]   <= wr_data_i;
                        3'd4:    freq0_q[15:12]  <= wr_data_i;
                        3'd5:    freq0_q[19:16]  <= wr_data_i;
                        3'd6:    vol_q[0]        <= wr_data_i;
                        default: ;
                    endcase
                end
                2'd1: begin
                    case (wr_addr_i[2:0])
                        3'd0:    wave_q[1]       <= wr_data_i;
                        3'd1:    freq1_q[3:0]    <= wr_data_i;
                        3'd2:    freq1_q[7:4]    <= wr_data_i;
                        3'd3:    freq1_q[11:8]   <= wr_data_i;
                        3'd4:    freq1_q[15:12]  <= wr_data_i;
                        3'd6:    vol_q[1]        <= wr_data_i;
                        default: ;
                    endcase
                end
                2'd2: begin
                    case (wr_addr_i[2:0])
                        3'd0:    wave_q[2]       <= wr_data_i;
                        3'd1:    freq2_q[3:0]    <= wr_data_i;
                        3'd2:    freq2_q[7:4]    <= wr_data_i;
                        3'd3:    freq2_q[11:8]   <= wr_data_i;
                        3'd4:    freq2_q[15:12]  <= wr_data_i;
                        3'd6:    vol_q[2]        <= wr_data_i;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_e      state_q;
    logic [1:0]  vi_q;
    logic [1:0]  wait_cnt_q;
    logic [9:0]  sum_q;
    logic [19:0] acc0_q;
    logic [15:0] acc1_q;
    logic [15:0] acc2_q;
    logic [7:0]  rom_addr_q;
    logic        rom_rd_q;
    logic [9:0]  mix_out_q;
    logic        mix_valid_q;
    logic        busy_q;
    logic        overrun_q;

    // Next phase and ROM address for the voice currently selected by vi_q.
    // Only the selected accumulator moves, and only when sound is enabled.
    logic [19:0] acc0_d;
    logic [15:0] acc1_d;
    logic [15:0] acc2_d;
    logic [7:0]  rom_addr_d;
    logic [3:0]  vol_sel;
    logic [7:0]  prod;
    logic [9:0]  sum_d;

    always_comb begin
        acc0_d     = acc0_q;
        acc1_d     = acc1_q;
        acc2_d     = acc2_q;
        rom_addr_d = '0;
        vol_sel    = '0;
        case (vi_q)
            2'd0: begin
                if (sound_enable_i) begin
                    acc0_d = acc0_q + freq0_q;
                end
                rom_addr_d = {wave_q[0][2:0], acc0_d[19:15]};
                vol_sel    = vol_q[0];
            end
            2'd1: begin
                if (sound_enable_i) begin
                    acc1_d = acc1_q + freq1_q;
                end
                rom_addr_d = {wave_q[1][2:0], acc1_d[15:11]};
                vol_sel    = vol_q[1];
            end
            2'd2: begin
                if (sound_enable_i) begin
                    acc2_d = acc2_q + freq2_q;
                end
                rom_addr_d = {wave_q[2][2:0], acc2_d[15:11]};
                vol_sel    = vol_q[2];
            end
            default: ;
        endcase
        // 4x4 product fits 8 bits; three of them (max 675) fit the 10-bit sum.
        prod  = 8'(rom_data_i[3:0]) * 8'(vol_sel);
        sum_d = sum_q + 10'(prod);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            vi_q        <= '0;
            wait_cnt_q  <= '0;
            sum_q       <= '0;
            acc0_q      <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            rom_addr_q  <= '0;
            rom_rd_q    <= 1'b0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rom_rd_q    <= 1'b0;
            mix_valid_q <= 1'b0;

            // A tick while not idle (DONE included) is dropped and remembered.
            if (sample_tick_i && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (sample_tick_i) begin
                        vi_q     <= '0;
                        sum_q    <= '0;
                        rom_rd_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= StAddr;
                    end
                end
                StAddr: begin
                    acc0_q     <= acc0_d;
                    acc1_q     <= acc1_d;
                    acc2_q     <= acc2_d;
                    rom_addr_q <= rom_addr_d;
                    wait_cnt_q <= '0;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (wait_cnt_q == LastWait) begin
                        state_q <= StAccum;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                StAccum: begin
                    sum_q <= sum_d;
                    if (vi_q == 2'd2) begin
                        state_q <= StDone;
                    end else begin
                        vi_q     <= vi_q + 2'd1;
                        rom_rd_q <= 1'b1;
                        state_q  <= StAddr;
                    end
                end
                StDone: begin
                    mix_out_q   <= sound_enable_i ? sum_q : 10'd0;
                    mix_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rom_addr_o  = rom_addr_q;
    assign rom_rd_o    = rom_rd_q;
    assign mix_out_o   = mix_out_q;
    assign mix_valid_o = mix_valid_q;
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;

    // Bits that are stored or received but deliberately not used.
    logic unused_bits;
    assign unused_bits = ^{rom_data_i[7:4], wave_q[0][3], wave_q[1][3], wave_q[2][3]};

endmodule

// File: tb/tb_namco_wsg_sequencer.sv
// Testbench for namco_wsg_sequencer: table of per-tick vectors with
// hand-computed ROM addresses and mixes, plus hand-written sequences for
// overrun, back-to-back ticks and reset in the middle of a sequence.
module tb_namco_wsg_sequencer;

    localparam int unsigned L   = 1;
    localparam int          Lat = 3 * (L + 2) + 1;
    localparam int          Win = 2 * Lat + 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic       sound_enable = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [7:0] rom_addr;
    logic       rom_rd;
    logic [7:0] rom_data;
    logic [9:0] mix_out;
    logic       mix_valid;
    logic       busy;
    logic       overrun;

    always #5 clk = ~clk;

    namco_wsg_sequencer #(.ROM_LATENCY(L)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .sample_tick_i (sample_tick),
        .sound_enable_i(sound_enable),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .rom_addr_o    (rom_addr),
        .rom_rd_o      (rom_rd),
        .rom_data_i    (rom_data),
        .mix_out_o     (mix_out),
        .mix_valid_o   (mix_valid),
        .busy_o        (busy),
        .overrun_o     (overrun)
    );

    // ROM model: data = address (or 0xFF when forced), L cycles of latency.
    logic       rom_ff = 1'b0;
    logic [7:0] rom_pipe [L];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_ff ? 8'hFF : rom_addr;
        for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[L-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic setup(input int s);
        case (s)
            1: begin  // v0 wave 3, freq 0x08000, vol 15
                wr(5'h00, 4'h3); wr(5'h04, 4'h8); wr(5'h06, 4'hF);
            end
            2: begin  // v1 wave 0, freq 0xF000, vol 1, plus ignored offset 5
                wr(5'h0C, 4'hF); wr(5'h0E, 4'h1); wr(5'h0D, 4'hF);
            end
            3: begin  // all volumes 15
                wr(5'h06, 4'hF); wr(5'h0E, 4'hF); wr(5'h16, 4'hF);
            end
            4: begin  // v2 wave 5, freq 0x0800, vol 3, plus ignored addresses
                wr(5'h10, 4'h5); wr(5'h13, 4'h8); wr(5'h16, 4'h3);
                wr(5'h15, 4'hF); wr(5'h17, 4'hF); wr(5'h1F, 4'hF);
            end
            default: ;
        endcase
    endtask

    logic [7:0] addrq [$];

    // Tick at cycle 0 and optionally at cycle t2; observe Win cycles.
    task automatic run_seq(input int t2, output int nvalid, output int lat0, output int lat1,
                           output int m0, output int m1, output int busy_c1);
        logic prev_rd;
        prev_rd = 1'b0;
        addrq.delete();
        nvalid = 0; lat0 = -1; lat1 = -1; m0 = -1; m1 = -1; busy_c1 = 0;
        for (int n = 0; n < Win; n++) begin
            sample_tick = (n == 0) || (n == t2);
            @(negedge clk);
            if (prev_rd) addrq.push_back(rom_addr);
            prev_rd = rom_rd;
            if (n == 1) busy_c1 = int'(busy);
            if (mix_valid) begin
                if (nvalid == 0) begin lat0 = n; m0 = int'(mix_out); end
                else if (nvalid == 1) begin lat1 = n; m1 = int'(mix_out); end
                nvalid++;
            end
        end
        sample_tick = 1'b0;
    endtask

    typedef struct {
        bit         do_rst;
        int         su;
        bit         en;
        bit         ff;
        logic [7:0] a0, a1, a2;
        int         mix;
    } vec_t;

    vec_t vecs [10];
    int nv, l0, l1, m0, m1, b1;

    initial begin
        vecs[0] = '{1'b1, 1, 1'b1, 1'b0, 8'h61, 8'h00, 8'h00, 15};
        vecs[1] = '{1'b0, 0, 1'b1, 1'b0, 8'h62, 8'h00, 8'h00, 30};
        vecs[2] = '{1'b1, 2, 1'b1, 1'b0, 8'h00, 8'h1E, 8'h00, 14};
        vecs[3] = '{1'b0, 0, 1'b1, 1'b0, 8'h00, 8'h1C, 8'h00, 12};
        vecs[4] = '{1'b1, 3, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 675};
        vecs[5] = '{1'b1, 4, 1'b1, 1'b0, 8'h00, 8'h00, 8'hA1, 3};
        vecs[6] = '{1'b0, 0, 1'b1, 1'b0, 8'h00, 8'h00, 8'hA2, 6};
        vecs[7] = '{1'b1, 1, 1'b1, 1'b0, 8'h61, 8'h00, 8'h00, 15};
        vecs[8] = '{1'b0, 0, 1'b0, 1'b0, 8'h61, 8'h00, 8'h00, 0};
        vecs[9] = '{1'b0, 0, 1'b1, 1'b0, 8'h62, 8'h00, 8'h00, 30};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst rom_addr", int'(rom_addr), 0);
        chk("rst rom_rd", int'(rom_rd), 0);
        chk("rst mix_out", int'(mix_out), 0);
        chk("rst mix_valid", int'(mix_valid), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst overrun", int'(overrun), 0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven ticks
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_rst) do_reset();
            setup(vecs[i].su);
            sound_enable = vecs[i].en;
            rom_ff       = vecs[i].ff;
            run_seq(-1, nv, l0, l1, m0, m1, b1);
            chk($sformatf("v%0d nvalid", i), nv, 1);
            chk($sformatf("v%0d latency", i), l0, Lat);
            chk($sformatf("v%0d mix", i), m0, vecs[i].mix);
            chk($sformatf("v%0d nreads", i), addrq.size(), 3);
            if (addrq.size() >= 3) begin
                chk($sformatf("v%0d addr0", i), int'(addrq[0]), int'(vecs[i].a0));
                chk($sformatf("v%0d addr1", i), int'(addrq[1]), int'(vecs[i].a1));
                chk($sformatf("v%0d addr2", i), int'(addrq[2]), int'(vecs[i].a2));
            end
        end
        sound_enable = 1'b1;
        rom_ff       = 1'b0;

        // Tick in the cycle the FSM returns to IDLE is accepted
        do_reset();
        setup(1);
        run_seq(Lat + 1, nv, l0, l1, m0, m1, b1);
        chk("b2b nvalid", nv, 2);
        chk("b2b lat1", l1, 2 * Lat + 1);
        chk("b2b mix0", m0, 15);
        chk("b2b mix1", m1, 30);
        chk("b2b overrun", int'(overrun), 0);

        // Tick during DONE is dropped
        do_reset();
        setup(1);
        run_seq(Lat, nv, l0, l1, m0, m1, b1);
        chk("done-tick nvalid", nv, 1);
        chk("done-tick overrun", int'(overrun), 1);

        // Tick 4 cycles after the first: dropped, overrun sticky
        do_reset();
        setup(1);
        run_seq(4, nv, l0, l1, m0, m1, b1);
        chk("ovr nvalid", nv, 1);
        chk("ovr mix", m0, 15);
        chk("ovr busy", b1, 1);
        chk("ovr overrun", int'(overrun), 1);
        run_seq(-1, nv, l0, l1, m0, m1, b1);
        chk("ovr next nvalid", nv, 1);
        chk("ovr next mix", m0, 30);
        chk("ovr sticky", int'(overrun), 1);

        // Reset during WAIT of v1
        do_reset();
        setup(1);
        wr(5'h08, 4'h7);
        run_seq(-1, nv, l0, l1, m0, m1, b1);
        chk("midrst pre mix", m0, 15);
        for (int n = 0; n <= L + 3; n++) begin
            sample_tick = (n == 0);
            @(negedge clk);
        end
        sample_tick = 1'b0;
        chk("midrst pre busy", int'(busy), 1);
        chk("midrst pre addr", int'(rom_addr), 8'hE0);
        reset = 1'b1;
        #1;
        chk("midrst rom_addr", int'(rom_addr), 0);
        chk("midrst rom_rd", int'(rom_rd), 0);
        chk("midrst mix_out", int'(mix_out), 0);
        chk("midrst mix_valid", int'(mix_valid), 0);
        chk("midrst busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        nv = 0;
        for (int n = 0; n < Win; n++) begin
            @(negedge clk);
            if (mix_valid) nv++;
        end
        chk("midrst no valid", nv, 0);
        setup(1);
        run_seq(-1, nv, l0, l1, m0, m1, b1);
        chk("midrst restart mix", m0, 15);
        chk("midrst restart nreads", addrq.size(), 3);
        if (addrq.size() >= 1) chk("midrst restart addr0", int'(addrq[0]), 8'h61);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/namco_wsg_sequencer.md
Name: namco_wsg_sequencer

Overview:
- Time-multiplexed controller for the 3-voice waveform sound generator.
- Holds the CPU-written nibble sound registers and steps the per-voice phase accumulators once per sample tick.
- Arbitrates a single shared waveform ROM port between the three voices, in fixed order v0, v1, v2.
- Produces one volume-weighted mix per tick for the downstream PWM stage.

Parameters:
ROM_LATENCY, 1, cycles from rom_addr registered to rom_data valid (1..4)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sample_tick  input  1  one-cycle pulse at the audio sample rate (96 kHz)
sound_enable  input  1  0 = hold accumulators, mix forced to 0
wr_en  input  1  CPU sound-register write strobe
wr_addr  input  5  sound-register address
wr_data  input  4  sound-register nibble
rom_addr  output  8  shared waveform ROM address
rom_rd  output  1  high during the ADDR cycle of each voice
rom_data  input  8  waveform ROM byte; low nibble is the sample
mix_out  output  10  mixed sample
mix_valid  output  1  one-cycle pulse when mix_out updates
busy  output  1  high whenever FSM is not IDLE
overrun  output  1  sticky; set when a tick is dropped

Behaviour:
- Reset is asynchronous, active-high. While asserted:
  - all outputs are 0;
  - all sound registers and accumulators are 0;
  - FSM goes to IDLE.
  - A reset mid-sequence abandons the sequence; no mix_valid is produced.
- Register map: voice v base = 8*v (0x00, 0x08, 0x10).
  - Offset 0: wave[2:0]; bit 3 stored, unused.
  - Offsets 1..5: freq nibbles, least significant first.
  - Offset 6: volume.
  - Voice 0 freq is 20 bits (offsets 1..5).
  - Voices 1 and 2 freq are 16 bits (offsets 1..4); their offset 5 is ignored.
  - Offsets 7 and 0x18..0x1F are ignored.
- Writes take effect at the clk edge with wr_en = 1 and are accepted in any FSM state.
- FSM states: IDLE, ADDR, WAIT, ACCUM, DONE; voice index vi runs 0..2.
- IDLE:
  - on sample_tick: vi = 0, sum = 0, go to ADDR.
- ADDR (1 cycle):
  - if sound_enable = 1: acc[vi] += freq[vi], modulo the accumulator width (20 bits for v0, 16 bits for v1/v2).
  - rom_addr is registered as {wave[vi][2:0], new_acc[top 5 bits]}.
  - If sound_enable = 0, the accumulator holds and the held value forms the address.
  - Register values are sampled in this cycle; a same-cycle write is not seen until the next tick.
  - rom_rd = 1.
- WAIT: ROM_LATENCY cycles, rom_addr held.
- ACCUM (1 cycle):
  - sum += rom_data[3:0] * vol[vi], computed as 8-bit product into a 10-bit sum; maximum is 3*225 = 675, so no overflow.
  - If vi < 2: vi++ and go to ADDR. Otherwise go to DONE.
- DONE (1 cycle):
  - mix_out <= sound_enable ? sum : 0;
  - mix_valid = 1 in the following cycle;
  - go to IDLE.
- Latency: tick sampled at edge 0 → mix_valid high in cycle 3*(ROM_LATENCY+2)+1, which is cycle 10 for ROM_LATENCY = 1.
- mix_out holds its value between updates.
- sample_tick seen while busy = 1 (including the DONE cycle):
  - the tick is dropped and overrun is set;
  - the in-flight sequence is unaffected.
  - overrun clears only on reset.
- A tick arriving in the same cycle the FSM returns to IDLE is accepted.

Test Plan:
- Bench ROM returns data = rom_addr. Set v0 wave = 3, freq = 0x08000, vol = 15; other volumes 0. Two ticks → rom_addr for v0 = 0x61 then 0x62; mix_out = 15 then 30; mix_valid exactly 10 cycles after each tick.
- Set v1 wave = 0, freq = 0xF000, vol = 1; write offset 0x0D = 0xF. Two ticks → v1 rom_addr = 0x1E then 0x1C (16-bit wrap); the offset-5 write has no effect.
- All vol = 15, ROM returns 0xFF → mix_out = 675 (0x2A3), no overflow.
- Second tick issued 4 cycles after the first → single mix_valid, overrun = 1 and stays 1 through later normal ticks.
- Assert reset during WAIT of v1 → all outputs 0 at once, no mix_valid. Next tick restarts from acc = 0 and v0 rom_addr = {wave, 5'b00001} for freq = 0x08000.
- sound_enable = 0 across a tick → mix_out = 0, accumulators unchanged. Re-enable → sequence resumes from the held phase.
